// File: rtl/mux_rr_nch.sv
// N-channel W-bit valid/ready multiplexer with a registered output, fixed-select or round-robin source choice.
// Define MUX_RR_PARITY_EN to add the registered even-parity output out_par.
module mux_rr_nch #(
    parameter int N = 8,
    parameter int W = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         mode_rr,
    input  logic [$clog2(N)-1:0]         sel,
    input  logic [N*W-1:0]               in_data,
    input  logic [N-1:0]                 in_valid,
    output logic [N-1:0]                 in_ready,
    output logic [W-1:0]                 out_data,
    output logic [$clog2(N)-1:0]         out_chan,
    output logic                         out_valid,
    input  logic                         out_ready
`ifdef MUX_RR_PARITY_EN
    ,
    output logic                         out_par
`endif
);

    localparam int SELW = $clog2(N);

    logic [SELW-1:0] ptr_reg;
    logic [W-1:0]    out_data_reg;
    logic [SELW-1:0] out_chan_reg;
    logic            out_valid_reg;

    logic [W-1:0]    chan_data [N];
    logic [N-1:0]    hi_mask;
    logic [N-1:0]    rr_masked;
    logic [N-1:0]    rr_search;
    logic [SELW-1:0] rr_g;
    logic            fx_valid;
    logic [SELW-1:0] g;
    logic            grant_exists;
    logic            load;
    logic            xfer;

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_chan
            assign chan_data[gi] = in_data[gi*W +: W];
            assign hi_mask[gi]   = (SELW'(gi) >= ptr_reg);
            assign in_ready[gi]  = rst_n & xfer & (g == SELW'(gi));
        end
    endgenerate

    // Search from ptr upward first; if nothing is valid there, wrap to the lowest valid channel.
    assign rr_masked = in_valid & hi_mask;
    assign rr_search = (|rr_masked) ? rr_masked : in_valid;

    always_comb begin
        rr_g = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (rr_search[k]) begin
                rr_g = SELW'(k);
            end
        end
    end

    // Explicit compare loop so an out-of-range sel simply finds no channel.
    always_comb begin
        fx_valid = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (int'(sel) == k) begin
                fx_valid = in_valid[k];
            end
        end
    end

    assign g            = mode_rr ? rr_g : sel;
    assign grant_exists = mode_rr ? (|in_valid) : fx_valid;
    assign load         = !out_valid_reg || out_ready;
    assign xfer         = load && grant_exists;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_reg       <= '0;
            out_data_reg  <= '0;
            out_chan_reg  <= '0;
            out_valid_reg <= 1'b0;
        end else if (load) begin
            out_valid_reg <= grant_exists;
            if (grant_exists) begin
                out_data_reg <= chan_data[g];
                out_chan_reg <= g;
                if (mode_rr) begin
                    ptr_reg <= (int'(g) == N - 1) ? '0 : g + 1'b1;
                end
            end
        end
    end

    assign out_data  = out_data_reg;
    assign out_chan  = out_chan_reg;
    assign out_valid = out_valid_reg;

`ifdef MUX_RR_PARITY_EN
    logic out_par_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_par_reg <= 1'b0;
        end else if (xfer) begin
            out_par_reg <= ^chan_data[g];
        end
    end

    assign out_par = out_par_reg;
`endif

endmodule

// File: tb/tb_mux_rr_nch.sv
// Scoreboard bench for mux_rr_nch (N=8, W=8): stimulus pushes expected words, a monitor pops on each accepted output.
module tb_mux_rr_nch;

    localparam int N = 8;
    localparam int W = 8;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           mode_rr;
    logic [2:0]     sel;
    logic [N*W-1:0] in_data;
    logic [N-1:0]   in_valid;
    logic [N-1:0]   in_ready;
    logic [W-1:0]   out_data;
    logic [2:0]     out_chan;
    logic           out_valid;
    logic           out_ready;
`ifdef MUX_RR_PARITY_EN
    logic           out_par;
`endif

    typedef struct packed {
        logic [2:0] chan;
        logic [7:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    mux_rr_nch #(.N(N), .W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mode_rr   (mode_rr),
        .sel       (sel),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_chan  (out_chan),
        .out_valid (out_valid),
        .out_ready (out_ready)
`ifdef MUX_RR_PARITY_EN
        ,
        .out_par   (out_par)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end else begin
            $display("ok   %s value=%0h", name, act);
        end
    endtask

    task automatic push(input int ch);
        exp_t e;
        e.chan = 3'(ch);
        e.data = 8'(1 << ch);
        exp_q.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every accepted output word must match the head of the scoreboard.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_word", {21'd0, out_chan, out_data}, 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("out_chan", 32'(out_chan), 32'(e.chan));
                chk("out_data", 32'(out_data), 32'(e.data));
`ifdef MUX_RR_PARITY_EN
                chk("out_par", 32'(out_par), 32'(^e.data));
`endif
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    int rr_seq [6] = '{0, 2, 5, 7, 0, 2};

    initial begin
        rst_n     = 1'b0;
        mode_rr   = 1'b0;
        sel       = '0;
        out_ready = 1'b1;
        in_valid  = '1;
        for (int i = 0; i < N; i++) in_data[i*W +: W] = 8'(1 << i);

        // Reset state with every input requesting
        #12;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_out_chan", 32'(out_chan), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
`ifdef MUX_RR_PARITY_EN
        chk("rst_out_par", 32'(out_par), 32'd0);
`endif
        step();
        rst_n    = 1'b1;
        in_valid = '0;
        step();
        chk("idle_out_valid", 32'(out_valid), 32'd0);

        // Fixed mode, sel stepped 0..7
        in_valid = '1;
        mode_rr  = 1'b0;
        for (int s = 0; s < N; s++) begin
            sel = 3'(s);
            push(s);
            #1;
            chk("fixed_in_ready", 32'(in_ready), 32'(1 << s));
            step();
        end
        in_valid = '0;
        step();
        chk("fixed_drain_valid", 32'(out_valid), 32'd0);

        // Round-robin over 1010_0101
        mode_rr  = 1'b1;
        in_valid = 8'b1010_0101;
        for (int k = 0; k < 6; k++) begin
            push(rr_seq[k]);
            step();
        end
        in_valid = '0;
        step();
        chk("rr_drain_valid", 32'(out_valid), 32'd0);

        // Backpressure: pointer now 3, so channel 5 is loaded and held
        out_ready = 1'b0;
        in_valid  = 8'b1010_0101;
        push(5);
        step();
        for (int k = 0; k < 5; k++) begin
            chk("bp_out_valid", 32'(out_valid), 32'd1);
            chk("bp_out_data", 32'(out_data), 32'h20);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            step();
        end
        out_ready = 1'b1;
        push(7);
        step();
        chk("nobubble_out_valid", 32'(out_valid), 32'd1);
        push(0);
        step();
        in_valid = '0;
        step();

        // Fixed mode on an idle channel: output empties after the pop
        mode_rr  = 1'b0;
        sel      = 3'd2;
        in_valid = 8'hF7;
        push(2);
        step();
        sel = 3'd3;
        #1;
        chk("nogrant_in_ready", 32'(in_ready), 32'd0);
        step();
        chk("nogrant_out_valid", 32'(out_valid), 32'd0);
        chk("nogrant_out_chan", 32'(out_chan), 32'd2);
        chk("nogrant_out_data", 32'(out_data), 32'h04);

        // Async reset mid-stream: pointer is 1, channel 1 goes out, channel 2 is dropped
        mode_rr  = 1'b1;
        in_valid = '1;
        push(1);
        step();
        step();
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", 32'(out_valid), 32'd0);
        chk("arst_out_data", 32'(out_data), 32'd0);
        chk("arst_out_chan", 32'(out_chan), 32'd0);
        chk("arst_in_ready", 32'(in_ready), 32'd0);
`ifdef MUX_RR_PARITY_EN
        chk("arst_out_par", 32'(out_par), 32'd0);
`endif
        step();
        rst_n    = 1'b1;
        in_valid = 8'b1010_0100;
        // Pointer was reset to 0, so the search restarts at channel 2
        push(2);
        step();
        push(5);
        step();
        push(7);
        step();
        in_valid = '0;
        step();
        step();
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
